// File: rtl/auc_pkg.sv
// Shared types and constants for the AUC sequential arithmetic stage.
// Optional flag generation in auc_seq_unit is enabled by defining AUC_FLAGS_EN.
package auc_pkg;

  localparam int AUC_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_XOR = 2'b11
  } auc_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } auc_state_e;

  localparam int FLG_CARRY  = 2;
  localparam int FLG_BORROW = 1;
  localparam int FLG_ZERO   = 0;

endpackage

// File: rtl/auc_shift_add_step.sv
// One shift-add multiply step: adds (a << i) to the accumulator when the
// selected multiplier bit is set. Purely combinational; iterated by the FSM.
module auc_shift_add_step
  import auc_pkg::*;
#(
  parameter  int WIDTH = AUC_W,
  localparam int RES_W = 2 * WIDTH,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [RES_W-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             b_bit_i,
  input  logic [IDX_W-1:0] i_i,
  output logic [RES_W-1:0] acc_o
);

  logic [RES_W-1:0] partial;

  always_comb begin
    partial = b_bit_i ? (RES_W'(a_i) << i_i) : '0;
    acc_o   = acc_i + partial;
  end

endmodule

// File: rtl/auc_seq_unit.sv
// Sequential ADD/SUB/MUL/XOR stage with valid/ready on both sides.
// Define AUC_FLAGS_EN to register {carry, borrow, zero}; otherwise flags is 0.
module auc_seq_unit
  import auc_pkg::*;
#(
  parameter  int WIDTH = AUC_W,
  localparam int RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic [2:0]       flags
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(WIDTH - 1);

  auc_state_e       state_q, state_d;
  auc_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] step_q;
  logic [RES_W-1:0] acc_q, result_q, mul_acc, exec_res;
  logic [WIDTH:0]   sum;
  logic             alive_q, accept, exec_done;

  assign accept    = in_valid && in_ready;
  assign exec_done = (state_q == S_EXEC) && ((op_q != OP_MUL) || (step_q == LAST_STEP));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  if (exec_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready stays low until the first clock edge after reset release.
  always_comb begin
    in_ready  = alive_q && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  auc_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .a_i     (a_q),
    .b_bit_i (b_q[step_q]),
    .i_i     (step_q),
    .acc_o   (mul_acc)
  );

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      OP_ADD:  exec_res = RES_W'(sum);
      OP_SUB:  exec_res = RES_W'(a_q) - RES_W'(b_q);
      OP_MUL:  exec_res = mul_acc;
      OP_XOR:  exec_res = RES_W'(a_q ^ b_q);
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= auc_op_e'(op);
        a_q    <= a;
        b_q    <= b;
        step_q <= '0;
        acc_q  <= '0;
      end else if (state_q == S_EXEC) begin
        step_q <= step_q + IDX_W'(1);
        acc_q  <= mul_acc;
      end
      if (exec_done) result_q <= exec_res;
    end
  end

  assign result = result_q;

`ifdef AUC_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  always_comb begin
    flags_d             = '0;
    flags_d[FLG_CARRY]  = (op_q == OP_ADD) && sum[WIDTH];
    flags_d[FLG_BORROW] = (op_q == OP_SUB) && (a_q < b_q);
    flags_d[FLG_ZERO]   = (exec_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         flags_q <= '0;
    else if (exec_done) flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_auc_seq_unit.sv
// Self-checking bench for auc_seq_unit: directed boundary cases plus random
// operations compared against an arithmetic reference model.
module tb_auc_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [3:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [2:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  auc_seq_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, wrapped to 8 bits.
  function automatic int ref_result(input int o, input int x, input int y);
    case (o)
      0:       return (x + y) & 8'hFF;
      1:       return (x - y) & 8'hFF;
      2:       return (x * y) & 8'hFF;
      default: return x ^ y;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input int o, input int x, input int y);
`ifdef AUC_FLAGS_EN
    logic [2:0] f;
    f[2] = (o == 0) && (x + y > 15);
    f[1] = (o == 1) && (x < y);
    f[0] = (ref_result(o, x, y) == 0);
    return f;
`else
    return 3'b000;
`endif
  endfunction

  // Issue one op, verify latency, result/flags, backpressure hold and return to IDLE.
  task automatic run_op(input int o, input int x, input int y, input int hold);
    int exp_res, cyc, exp_lat;
    logic [2:0] exp_flg;
    exp_res = ref_result(o, x, y);
    exp_flg = ref_flags(o, x, y);
    exp_lat = (o == 2) ? 4 : 1;
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 2'(o);
    a         = 4'(x);
    b         = 4'(y);
    out_ready = (hold == 0);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1));
    op = 2'($urandom);
    a  = 4'($urandom);
    b  = 4'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check("busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, exp_lat);
    check("result", result, exp_res);
    check("flags", flags, exp_flg);
    check("done_in_ready", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, exp_res);
      check("hold_flags", flags, exp_flg);
      check("hold_in_ready", in_ready, 0);
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ack_out_valid", out_valid, 0);
    check("ack_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    run_op(0, 15, 15, 0);
    run_op(1, 0, 15, 0);
    run_op(1, 7, 7, 0);
    run_op(2, 15, 15, 0);
    run_op(2, 0, 9, 0);
    run_op(3, 4'hA, 4'h5, 10);

    // Reset two cycles into a multiply.
    @(negedge clk);
    in_valid = 1'b1; op = 2'd2; a = 4'd15; b = 4'd15; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 3, 4, 0);

    for (int t = 0; t < 40; t++)
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
